// File: rtl/voice_envelope_amp.sv
// voice_envelope_amp: per-voice ADSR envelope generator and amplitude stage
module voice_envelope_amp #(
    parameter int DATA_BITS     = 12,
    parameter int ENV_BITS      = 8,
    parameter int RATE_BITS     = 4,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 gate,
    input  logic [RATE_BITS-1:0] attack,
    input  logic [RATE_BITS-1:0] decay,
    input  logic [3:0]           sustain,
    input  logic [RATE_BITS-1:0] release_rate,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [ENV_BITS-1:0]  env,
    output logic [2:0]           state,
    output logic                 active
);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
    localparam logic [ENV_BITS-1:0] ENV_MAX = '1;
    state_t                   cur, nxt;
    logic                     gate_q, rise, fall, step;
    logic [ENV_BITS-1:0]      env_n, sus_lvl;
    logic [PRESCALE_BITS-1:0] presc, presc_n, lim;
    logic [RATE_BITS-1:0]     r;
    logic [DATA_BITS+ENV_BITS-1:0] prod;
    assign rise    = gate & ~gate_q;
    assign fall    = ~gate & gate_q;
    assign sus_lvl = ENV_BITS'({(ENV_BITS/4+1){sustain}});
    assign r       = cur == ATTACK ? attack : cur == DECAY ? decay : release_rate;
    assign lim     = (PRESCALE_BITS'(1) << r) - PRESCALE_BITS'(1);
    assign step    = sample_tick & (presc == lim);
    assign prod    = {{ENV_BITS{1'b0}}, din} * env;
    assign state   = cur;
    assign active  = cur != IDLE;
    // Registers: state, envelope, prescaler, gate history and scaled sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= IDLE;
            env    <= '0;
            presc  <= '0;
            gate_q <= 1'b0;
            dout   <= '0;
        end else begin
            cur    <= nxt;
            env    <= env_n;
            presc  <= presc_n;
            gate_q <= gate;
            if (sample_tick) dout <= DATA_BITS'(prod >> ENV_BITS);
        end
    end
    // Next-state and envelope update; gate edges outrank rate steps
    always_comb begin
        nxt     = cur;
        env_n   = env;
        presc_n = sample_tick ? (step ? '0 : presc + 1'b1) : presc;
        if (rise) begin
            nxt = ATTACK;
        end else if (fall && (cur == ATTACK || cur == DECAY || cur == SUSTAIN)) begin
            nxt = RELEASE;
        end else begin
            case (cur)
                ATTACK: if (step) begin
                    if (env == ENV_MAX) nxt = DECAY;
                    else begin
                        env_n = env + 1'b1;
                        nxt   = env_n == ENV_MAX ? DECAY : ATTACK;
                    end
                end
                DECAY: if (step) begin
                    if (env <= sus_lvl) nxt = SUSTAIN;
                    else begin
                        env_n = env - 1'b1;
                        nxt   = env_n == sus_lvl ? SUSTAIN : DECAY;
                    end
                end
                SUSTAIN: env_n = sample_tick ? sus_lvl : env;
                RELEASE: if (step) begin
                    if (env == '0) nxt = IDLE;
                    else begin
                        env_n = env - 1'b1;
                        nxt   = env_n == '0 ? IDLE : RELEASE;
                    end
                end
                default: env_n = '0;
            endcase
        end
        if (rise || nxt != cur) presc_n = '0;
    end
endmodule

// File: tb/tb_voice_envelope_amp.sv
// tb_voice_envelope_amp: directed checks of envelope shape, amplitude and reset
module tb_voice_envelope_amp;
    logic        clk = 0, rst = 1, sample_tick = 0, gate = 0;
    logic [3:0]  attack = 0, decay = 0, sustain = 4'h8, release_rate = 0;
    logic [11:0] din = 0, dout;
    logic [7:0]  env;
    logic [2:0]  state;
    logic        active;
    int errors = 0, checks = 0;

    voice_envelope_amp dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
        .attack(attack), .decay(decay), .sustain(sustain), .release_rate(release_rate),
        .din(din), .dout(dout), .env(env), .state(state), .active(active)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n, input logic t);
        repeat (n) begin
            sample_tick = t;
            @(posedge clk);
            #1;
        end
        sample_tick = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(2, 0);
        chk("rst_env", env, 0); chk("rst_state", state, 0);
        chk("rst_dout", dout, 0); chk("rst_active", active, 0);
        rst = 0;
        cyc(1, 0);
        // attack=2: one step per 4 ticks, idle clocks do not count
        attack = 2; gate = 1;
        cyc(1, 0);
        chk("a2_rise_state", state, 1); chk("a2_rise_env", env, 0); chk("a2_active", active, 1);
        cyc(3, 1);  chk("a2_t3", env, 0);
        cyc(1, 1);  chk("a2_t4", env, 1);
        cyc(5, 0);  chk("a2_noticks", env, 1);
        cyc(4, 1);  chk("a2_t8", env, 2);
        cyc(184, 1); chk("a2_env30", env, 8'h30); chk("a2_state30", state, 1);
        // fall during attack, release=1: one step per 2 ticks
        release_rate = 1; gate = 0;
        cyc(1, 0);
        chk("rel_state", state, 4); chk("rel_env", env, 8'h30);
        cyc(2, 1);  chk("rel_t2", env, 8'h2f);
        cyc(93, 1); chk("rel_t95", env, 1); chk("rel_t95_state", state, 4);
        cyc(1, 1);  chk("rel_end_env", env, 0); chk("rel_end_state", state, 0);
        chk("rel_end_active", active, 0);
        // fast ADSR with all rates 0, sustain 0x88
        attack = 0; decay = 0; release_rate = 0; sustain = 4'h8; gate = 1;
        cyc(1, 1);  chk("f_rise", state, 1); chk("f_rise_env", env, 0);
        cyc(254, 1); chk("f_fe", env, 8'hfe); chk("f_fe_state", state, 1);
        cyc(1, 1);  chk("f_ff", env, 8'hff); chk("f_ff_state", state, 2);
        cyc(118, 1); chk("f_89", env, 8'h89); chk("f_89_state", state, 2);
        cyc(1, 1);  chk("f_88", env, 8'h88); chk("f_sus_state", state, 3);
        cyc(5, 1);  chk("f_hold", env, 8'h88); chk("f_hold_state", state, 3);
        // amplitude stage
        din = 12'hfff;
        cyc(1, 1);  chk("amp_88", dout, 12'h87f);
        din = 12'h123;
        cyc(3, 0);  chk("amp_hold", dout, 12'h87f);
        din = 12'hfff; sustain = 4'hf;
        cyc(1, 1);  chk("sus_up_env", env, 8'hff); chk("amp_pre_update", dout, 12'h87f);
        cyc(1, 1);  chk("amp_full", dout, 12'hfef);
        sustain = 4'h8;
        cyc(1, 1);  chk("sus_down_env", env, 8'h88);
        // retrigger from release at env=0x50, rise coinciding with a step
        release_rate = 1; gate = 0;
        cyc(1, 0);  chk("rt_rel_state", state, 4);
        cyc(112, 1); chk("rt_env50", env, 8'h50); chk("rt_rel_state2", state, 4);
        cyc(1, 1);  chk("rt_env50b", env, 8'h50);
        attack = 1; gate = 1;
        cyc(1, 1);  chk("rt_state", state, 1); chk("rt_env", env, 8'h50);
        cyc(1, 1);  chk("rt_t1", env, 8'h50);
        cyc(1, 1);  chk("rt_t2", env, 8'h51);
        // async reset mid-attack at env=0x40
        rst = 1; cyc(1, 0); rst = 0; gate = 0; attack = 0;
        cyc(1, 0);
        gate = 1;
        cyc(1, 0);
        cyc(64, 1); chk("ar_env40", env, 8'h40); chk("ar_dout", dout, 12'h3ef);
        #3 rst = 1;
        #1;
        chk("ar_env", env, 0); chk("ar_state", state, 0); chk("ar_dout0", dout, 0);
        chk("ar_active", active, 0);
        cyc(2, 1);
        chk("ar_hold_env", env, 0); chk("ar_hold_dout", dout, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
